// File: rtl/pad_input_conditioner.sv
// Gamepad/button front end: merges pads with board buttons, synchronises, debounces and
// edge-detects five channels, and produces DAS/ARR auto-repeat pulses for left, right and drop.
module pad_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 750000,
    parameter int DAS_CYCLES      = 12000000,
    parameter int ARR_CYCLES      = 3750000,
    parameter int CNT_W           = 24
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       en,
    input  logic       pad_L,
    input  logic       pad_R,
    input  logic       pad_U,
    input  logic       pad_D,
    input  logic       pad_S,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       btnU,
    input  logic       btnD,
    output logic       move_left,
    output logic       move_right,
    output logic       soft_drop,
    output logic       rotate,
    output logic       start,
    output logic [4:0] held
);

    localparam int NCH  = 5;
    localparam int NREP = 3;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } rep_state_t;

    // Channel order everywhere: {S, D, U, R, L}.
    logic [NCH-1:0]   w_raw;
    logic [NCH-1:0]   r_sync1;
    logic [NCH-1:0]   r_sync2;
    logic [NCH-1:0]   r_level;
    logic [NCH-1:0]   r_level_d;
    logic [NCH-1:0]   w_edge;
    logic [CNT_W-1:0] r_db_cnt [NCH];

    // Repeating channels: index 0 = L, 1 = R, 2 = D.
    rep_state_t       r_state     [NREP];
    rep_state_t       w_state_nxt [NREP];
    logic [CNT_W-1:0] r_rep_cnt   [NREP];
    logic [CNT_W-1:0] w_cnt_nxt   [NREP];
    logic [NREP-1:0]  w_rep_level;
    logic [NREP-1:0]  w_rep_edge;
    logic [NREP-1:0]  w_rival_edge;
    logic [NREP-1:0]  w_fire;
    logic [NCH-1:0]   r_pulse;

    assign w_raw = {pad_S, pad_D | btnD, pad_U | btnU, pad_R | btnR, pad_L | btnL};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_level   <= '0;
            r_level_d <= '0;
            // NOTE: the counter array is reset explicitly; it is real state, not a RAM.
            for (int i = 0; i < NCH; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            for (int i = 0; i < NCH; i++) begin
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_level[i]  <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CNT_ONE;
                end
            end
        end
    end

    assign w_edge       = r_level & ~r_level_d;
    assign w_rep_level  = {r_level[3], r_level[1], r_level[0]};
    assign w_rep_edge   = {w_edge[3], w_edge[1], w_edge[0]};
    // Left and right each yield to a fresh press of the other; drop has no rival.
    assign w_rival_edge = {1'b0, w_edge[0], w_edge[1]};

    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int c = 0; c < NREP; c++) begin
                r_state[c]   <= IDLE;
                r_rep_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NREP; c++) begin
                r_state[c]   <= w_state_nxt[c];
                r_rep_cnt[c] <= w_cnt_nxt[c];
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        for (int c = 0; c < NREP; c++) begin
            w_state_nxt[c] = r_state[c];
            w_cnt_nxt[c]   = r_rep_cnt[c];
            w_fire[c]      = 1'b0;
            if (!w_rep_level[c]) begin
                w_state_nxt[c] = IDLE;
                w_cnt_nxt[c]   = '0;
            end else begin
                case (r_state[c])
                    IDLE: begin
                        if (w_rep_edge[c]) begin
                            w_cnt_nxt[c] = '0;
                            if (w_rival_edge[c]) begin
                                w_state_nxt[c] = WAIT_REL;
                            end else begin
                                w_fire[c]      = 1'b1;
                                w_state_nxt[c] = DELAY;
                            end
                        end
                    end
                    DELAY: begin
                        if (w_rival_edge[c]) begin
                            w_state_nxt[c] = WAIT_REL;
                            w_cnt_nxt[c]   = '0;
                        end else if (r_rep_cnt[c] == DAS_LAST) begin
                            w_fire[c]      = 1'b1;
                            w_state_nxt[c] = REPEAT;
                            w_cnt_nxt[c]   = '0;
                        end else begin
                            w_cnt_nxt[c] = r_rep_cnt[c] + CNT_ONE;
                        end
                    end
                    REPEAT: begin
                        if (w_rival_edge[c]) begin
                            w_state_nxt[c] = WAIT_REL;
                            w_cnt_nxt[c]   = '0;
                        end else if (r_rep_cnt[c] == ARR_LAST) begin
                            w_fire[c]    = 1'b1;
                            w_cnt_nxt[c] = '0;
                        end else begin
                            w_cnt_nxt[c] = r_rep_cnt[c] + CNT_ONE;
                        end
                    end
                    default: begin
                        w_cnt_nxt[c] = '0;
                    end
                endcase
            end
        end
    end

    // Pulses are gated when decided and again when presented, so en=0 blocks them at once.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_pulse <= '0;
        end else begin
            r_pulse <= {w_edge[4], w_fire[2], w_edge[2], w_fire[1], w_fire[0]} & {NCH{en}};
        end
    end

    assign move_left  = r_pulse[0] & en;
    assign move_right = r_pulse[1] & en;
    assign rotate     = r_pulse[2] & en;
    assign soft_drop  = r_pulse[3] & en;
    assign start      = r_pulse[4] & en;
    assign held       = r_level;

endmodule
